// File: rtl/stream_max_min.sv
// Streaming frame statistics: collects N unsigned samples over valid/ready and
// reports running max, min and the first index of the max over a held result stream.
module stream_max_min #(
    parameter int W     = 4,
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     max,
    output logic [W-1:0]     min,
    output logic [IDX_W-1:0] max_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [W-1:0]     max_q, max_d;
    logic [W-1:0]     min_q, min_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            max_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        min_d   = min_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    // The first sample seeds both extremes; strict compares keep the earliest max index.
                    if (count_q == '0) begin
                        max_d = in_data;
                        min_d = in_data;
                        idx_d = '0;
                    end else begin
                        if (in_data > max_q) begin
                            max_d = in_data;
                            idx_d = count_q;
                        end
                        if (in_data < min_q) begin
                            min_d = in_data;
                        end
                    end
                    if (count_q == LAST) begin
                        state_d = HOLD;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Handshake outputs depend on state only, so no input reaches an output combinationally.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == COLLECT) || (state_q == HOLD);
    assign max       = max_q;
    assign min       = min_q;
    assign max_idx   = idx_q;

endmodule

// File: tb/tb_stream_max_min.sv
// Bench for stream_max_min: directed and random frames against a frame-level reference model.
module tb_stream_max_min;

    localparam int W     = 4;
    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef logic [W-1:0] frame_t [N];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     max;
    logic [W-1:0]     min;
    logic [IDX_W-1:0] max_idx;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    stream_max_min #(.W(W), .N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max       (max),
        .min       (min),
        .max_idx   (max_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: extremes over the whole frame, then the first position holding the max.
    function automatic void model(input frame_t s, output logic [W-1:0] mx,
                                  output logic [W-1:0] mn, output logic [IDX_W-1:0] ix);
        int best = 0;
        int worst = (1 << W) - 1;
        ix = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(s[i]) > best) best = int'(s[i]);
            if (int'(s[i]) < worst) worst = int'(s[i]);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(s[i]) == best) ix = IDX_W'(i);
        end
        mx = W'(best);
        mn = W'(worst);
    endfunction

    // Pulses start, then offers the frame. gap_mode: 0 none, 1 alternate (first idle), 2 random.
    // Returns the number of cycles in_ready was seen high. Ends on the negedge after the last accept.
    task automatic run_frame(input frame_t s, input int gap_mode, input int start_at,
                             output int cycles, output bit to);
        int  k = 0;
        int  iter = 0;
        bit  v;
        bit  rdy;
        cycles = 0;
        to = 1'b0;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        while (k < N) begin
            @(negedge clk);
            start = (k == start_at);
            rdy = in_ready;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? s[k] : (((iter % 4) >= 2) ? '1 : '0);
            if (rdy) cycles++;
            if (v && rdy) k++;
            iter++;
            if (iter > 200) begin
                to = 1'b1;
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, in_ready, busy, max, min, max_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b expected all zero", {out_valid, in_ready, busy, max, min, max_idx});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got=%b expected 000", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_ramp();
        frame_t s;
        int cyc;
        bit to;
        for (int i = 0; i < N; i++) s[i] = W'(i);
        run_frame(s, 0, -1, cyc, to);
        n_checks++;
        if (to || out_valid !== 1'b1 || cyc != N) begin
            n_fail++;
            $display("FAIL ramp_latency out_valid=%b cycles=%0d timeout=%0b expected 1/%0d/0", out_valid, cyc, to, N);
        end
        n_checks++;
        if ({max, min, max_idx} !== {4'd7, 4'd0, 3'd7}) begin
            n_fail++;
            $display("FAIL ramp_result got max=%0d min=%0d idx=%0d expected 7/0/7", max, min, max_idx);
        end
        do_accept();
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL ramp_release got=%b expected 00", {out_valid, busy});
        end
    endtask

    task automatic test_ties();
        frame_t s = '{4'd9, 4'd3, 4'd15, 4'd1, 4'd15, 4'd0, 4'd4, 4'd2};
        int cyc;
        bit to;
        run_frame(s, 0, -1, cyc, to);
        n_checks++;
        if (to || {out_valid, in_ready, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL ties_hold got vld/rdy/busy=%b expected 101", {out_valid, in_ready, busy});
        end
        n_checks++;
        if ({max, min, max_idx} !== {4'd15, 4'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL ties_result got max=%0d min=%0d idx=%0d expected 15/0/2", max, min, max_idx);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, max, min, max_idx} !== {1'b1, 4'd15, 4'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL ties_wait got vld=%b max=%0d min=%0d idx=%0d", out_valid, max, min, max_idx);
        end
        do_accept();
        n_checks++;
        if ({out_valid, busy, max, max_idx} !== {1'b0, 1'b0, 4'd15, 3'd2}) begin
            n_fail++;
            $display("FAIL ties_idle_keep got vld=%b busy=%b max=%0d idx=%0d expected 0/0/15/2", out_valid, busy, max, max_idx);
        end
    endtask

    task automatic test_gaps();
        frame_t s;
        int cyc;
        bit to;
        for (int i = 0; i < N; i++) s[i] = 4'd5;
        run_frame(s, 1, -1, cyc, to);
        n_checks++;
        if (to || cyc != 16 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_cycles got cycles=%0d out_valid=%b expected 16/1", cyc, out_valid);
        end
        n_checks++;
        if ({max, min, max_idx} !== {4'd5, 4'd5, 3'd0}) begin
            n_fail++;
            $display("FAIL gaps_result got max=%0d min=%0d idx=%0d expected 5/5/0", max, min, max_idx);
        end
        do_accept();
    endtask

    task automatic test_backpressure();
        frame_t s;
        logic [W-1:0] mx, mn;
        logic [IDX_W-1:0] ix;
        int cyc;
        bit to;
        for (int i = 0; i < N; i++) s[i] = W'($urandom_range(0, 15));
        model(s, mx, mn, ix);
        run_frame(s, 0, -1, cyc, to);
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if ({out_valid, in_ready, max, min, max_idx} !== {1'b1, 1'b0, mx, mn, ix}) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b max=%0d min=%0d idx=%0d expected 1/0/%0d/%0d/%0d",
                         c, out_valid, in_ready, max, min, max_idx, mx, mn, ix);
            end
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            in_data  = W'($urandom_range(0, 15));
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        do_accept();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t s = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd14};
        logic [W-1:0] part [4] = '{4'd9, 4'd3, 4'd12, 4'd6};
        int cyc;
        bit to;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_data = part[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, busy, max, min, max_idx} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async got=%b expected all zero", {out_valid, in_ready, busy, max, min, max_idx});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(s, 0, -1, cyc, to);
        n_checks++;
        if (to || {out_valid, max, min, max_idx} !== {1'b1, 4'd14, 4'd8, 3'd7}) begin
            n_fail++;
            $display("FAIL midreset_frame got vld=%b max=%0d min=%0d idx=%0d expected 1/14/8/7", out_valid, max, min, max_idx);
        end
        do_accept();
    endtask

    task automatic test_start_in_collect();
        frame_t s;
        logic [W-1:0] mx, mn;
        logic [IDX_W-1:0] ix;
        int cyc;
        bit to;
        for (int i = 0; i < N; i++) s[i] = W'($urandom_range(0, 15));
        model(s, mx, mn, ix);
        run_frame(s, 0, 3, cyc, to);
        n_checks++;
        if (to || cyc != N || {out_valid, max, min, max_idx} !== {1'b1, mx, mn, ix}) begin
            n_fail++;
            $display("FAIL start_ignored got vld=%b cyc=%0d max=%0d min=%0d idx=%0d expected 1/%0d/%0d/%0d/%0d",
                     out_valid, cyc, max, min, max_idx, N, mx, mn, ix);
        end
        do_accept();
    endtask

    task automatic test_random_frames();
        frame_t s;
        logic [W-1:0] mx, mn;
        logic [IDX_W-1:0] ix;
        int cyc;
        bit to;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < N; i++) s[i] = W'($urandom_range(0, 15));
            model(s, mx, mn, ix);
            run_frame(s, 2, -1, cyc, to);
            n_checks++;
            if (to || {out_valid, max, min, max_idx} !== {1'b1, mx, mn, ix}) begin
                n_fail++;
                $display("FAIL random_frame%0d got vld=%b max=%0d min=%0d idx=%0d expected 1/%0d/%0d/%0d",
                         f, out_valid, max, min, max_idx, mx, mn, ix);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_accept();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_release%0d got out_valid=%b expected 0", f, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ties();
        test_gaps();
        test_backpressure();
        test_reset_mid_frame();
        test_start_in_collect();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_max_min.md
Name: stream_max_min

Overview:
Sequential counterpart to the combinational two-input max comparator. Accepts a frame of N unsigned samples over a valid/ready input stream and tracks the running maximum, minimum and index of the maximum. Presents the frame result on a valid/ready output stream. Serves as the streaming result producer, fed by stimulus or upstream datapath blocks in the lab designs.

Parameters:
W, 4, sample width in bits (unsigned)
N, 8, samples per frame (N >= 2)
IDX_W, 3, index width; must satisfy 2**IDX_W >= N

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  W  sample value
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
max  output  W  largest sample in the frame
min  output  W  smallest sample in the frame
max_idx  output  IDX_W  0-based position of the first occurrence of max
busy  output  1  high in COLLECT and HOLD

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, independent of clk): state=IDLE, count=0. Outputs in_ready=0, out_valid=0, busy=0, max=0, min=0, max_idx=0.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE: in_ready=0, out_valid=0. If start=1 -> COLLECT and count=0. max, min and max_idx keep the previous frame's values.
- COLLECT: in_ready=1. A sample is accepted on any edge where in_valid && in_ready. Cycles with in_valid=0 leave all state unchanged.
- First accepted sample (count==0): max=min=in_data, max_idx=0.
- Later samples:
  - If in_data > max: max=in_data and max_idx=count. The compare is strict, so ties keep the earlier index.
  - If in_data < min: min=in_data.
  - Both compares are unsigned, W bits.
- Each accepted sample increments count. When sample number N-1 is accepted, go to HOLD and clear count. No wrap beyond N-1.
- Latency: out_valid=1 on the cycle after the Nth sample is accepted. The updated max, min and max_idx are visible on that same cycle.
- HOLD: in_ready=0, out_valid=1. max, min and max_idx are stable until the handshake. When out_valid && out_ready -> IDLE, with out_valid=0 the next cycle.
- Ignored inputs:
  - start in COLLECT or HOLD has no effect.
  - in_valid in IDLE or HOLD is not consumed.
- Backpressure: out_ready may stay low indefinitely. The result must be held unchanged.
- Reset mid-frame: any partial frame is discarded and all values return to the reset values above.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from state only.

Test Plan:
1. Reset, start, then samples 0..7 with no gaps -> out_valid rises the cycle after sample 7; max=7, min=0, max_idx=7.
2. Samples 9,3,15,1,15,0,4,2 -> max=15, min=0, max_idx=2 (first occurrence wins); result holds until out_ready, then IDLE.
3. All samples =5, with in_valid low on every other cycle -> 16 cycles in COLLECT; max=5, min=5, max_idx=0; no extra samples accepted.
4. Backpressure: after the result, hold out_ready=0 for 20 cycles while toggling in_valid and start -> outputs constant, in_ready=0; pulse out_ready -> out_valid=0 the next cycle.
5. Reset mid-frame: rst_n=0 after 4 samples, asynchronously between edges -> outputs 0 immediately; a new frame 8,8,8,8,8,8,8,14 -> max=14, max_idx=7, min=8.
6. start asserted in COLLECT after 3 samples -> ignored; the frame completes after 8 samples total, with the result checked against a reference model (scoreboard comparing max/min/max_idx, reporting mismatches).
